// File: rtl/ama_riscv_test_monitor_if.sv
// ama_riscv_test_monitor_if
// Bundles the observation inputs and readout outputs of the run monitor.
//   master : testbench / core side, drives the observed signals and rd_sel
//   slave  : the monitor, drives rd_data, state, done, pass, fail_code, rf_cov*
interface ama_riscv_test_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 64
);
  localparam int SEL_W = $clog2(NUM_EVT + 3);

  logic               start;
  logic               inst_retire;
  logic               stall;
  logic [NUM_EVT-1:0] evt;
  logic               rf_we;
  logic [4:0]         rf_addr;
  logic               tohost_we;
  logic [31:0]        tohost_data;
  logic [CNT_W-1:0]   timeout_clocks;
  logic [SEL_W-1:0]   rd_sel;

  logic [CNT_W-1:0]   rd_data;
  logic [2:0]         state;
  logic               done;
  logic               pass;
  logic [30:0]        fail_code;
  logic [31:0]        rf_cov;
  logic               rf_cov_all;

  modport master (
    output start, inst_retire, stall, evt, rf_we, rf_addr,
           tohost_we, tohost_data, timeout_clocks, rd_sel,
    input  rd_data, state, done, pass, fail_code, rf_cov, rf_cov_all
  );

  modport slave (
    input  start, inst_retire, stall, evt, rf_we, rf_addr,
           tohost_we, tohost_data, timeout_clocks, rd_sel,
    output rd_data, state, done, pass, fail_code, rf_cov, rf_cov_all
  );
endinterface

// File: rtl/ama_riscv_test_monitor.sv
// ama_riscv_test_monitor
// Run monitor beside the core: detects tohost pass/fail, runs a watchdog,
// keeps saturating cycle/instret/stall/event counters and an RF first-write
// coverage bitmap. Counters are read back through a registered select port.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   mon        : slave side of ama_riscv_test_monitor_if (observed signals in,
//                rd_data/state/done/pass/fail_code/rf_cov/rf_cov_all out)
module ama_riscv_test_monitor #(
  parameter int          NUM_EVT     = 4,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] TOHOST_PASS = 32'd1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ama_riscv_test_monitor_if.slave mon
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  state_e      state_q, state_d;
  cnt_t        cyc_q, cyc_d;
  cnt_t        ret_q, ret_d;
  cnt_t        stl_q, stl_d;
  cnt_t        rd_q, rd_d;
  cnt_t        evt_q [NUM_EVT];
  cnt_t        evt_d [NUM_EVT];
  logic [31:0] cov_q, cov_d;
  logic [30:0] fc_q, fc_d;
  logic        done_q, pass_q, cov_all_q;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input logic inc);
    if (inc && (v != '1)) return v + cnt_t'(1);
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ret_d   = ret_q;
    stl_d   = stl_q;
    evt_d   = evt_q;
    cov_d   = cov_q;
    fc_d    = fc_q;

    case (state_q)
      S_RUN: begin
        cyc_d = sat_inc(cyc_q, 1'b1);
        ret_d = sat_inc(ret_q, mon.inst_retire);
        stl_d = sat_inc(stl_q, mon.stall);
        for (int i = 0; i < NUM_EVT; i++) begin
          evt_d[i] = sat_inc(evt_q[i], mon.evt[i]);
        end
        if (mon.rf_we) cov_d[mon.rf_addr] = 1'b1;

        // A completing tohost write outranks the watchdog on the same cycle;
        // writes with bit 0 clear are progress reports and are ignored.
        if (mon.tohost_we && mon.tohost_data[0]) begin
          if (mon.tohost_data == TOHOST_PASS) begin
            state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            fc_d    = mon.tohost_data[31:1];
          end
        end else if ((mon.timeout_clocks != '0) && (cyc_d == mon.timeout_clocks)) begin
          state_d = S_TIMEOUT;
        end
      end
      // IDLE and terminal states hold everything until start; any illegal
      // encoding also recovers through start.
      default: begin
        if (mon.start) begin
          state_d = S_RUN;
          cyc_d   = '0;
          ret_d   = '0;
          stl_d   = '0;
          for (int i = 0; i < NUM_EVT; i++) evt_d[i] = '0;
          cov_d   = 32'h1;
          fc_d    = '0;
        end
      end
    endcase
  end

  // Readout mux samples the current (pre-update) counter values.
  always_comb begin
    rd_d = '0;
    if (int'(mon.rd_sel) == 0)      rd_d = cyc_q;
    else if (int'(mon.rd_sel) == 1) rd_d = ret_q;
    else if (int'(mon.rd_sel) == 2) rd_d = stl_q;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (int'(mon.rd_sel) == i + 3) rd_d = evt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      ret_q     <= '0;
      stl_q     <= '0;
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
      cov_q     <= '0;
      fc_q      <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cov_all_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      stl_q     <= stl_d;
      evt_q     <= evt_d;
      cov_q     <= cov_d;
      fc_q      <= fc_d;
      rd_q      <= rd_d;
      // Status flags get their own flops so outputs have no logic behind them.
      done_q    <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      pass_q    <= (state_d == S_PASS);
      cov_all_q <= &cov_d;
    end
  end

  assign mon.rd_data    = rd_q;
  assign mon.state      = state_q;
  assign mon.done       = done_q;
  assign mon.pass       = pass_q;
  assign mon.fail_code  = fc_q;
  assign mon.rf_cov     = cov_q;
  assign mon.rf_cov_all = cov_all_q;
endmodule

// File: tb/tb_ama_riscv_test_monitor.sv
// Testbench for ama_riscv_test_monitor (NUM_EVT=2, CNT_W=8).
// Directed scenarios with randomized side traffic, every cycle compared
// against a rule-level reference model.
module tb_ama_riscv_test_monitor;
  localparam int NE   = 2;
  localparam int CW   = 8;
  localparam int MAXC = 255;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PASS = 2, ST_FAIL = 3, ST_TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ama_riscv_test_monitor_if #(.NUM_EVT(NE), .CNT_W(CW)) bus ();

  ama_riscv_test_monitor #(
    .NUM_EVT    (NE),
    .CNT_W      (CW),
    .TOHOST_PASS(32'd1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  int          m_state;
  int          m_cyc, m_ret, m_stl;
  int          m_evt [NE];
  logic [31:0] m_cov;
  logic [30:0] m_fc;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic int model_rd(input int sel);
    case (sel)
      0:       return m_cyc;
      1:       return m_ret;
      2:       return m_stl;
      3:       return m_evt[0];
      4:       return m_evt[1];
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE;
    m_cyc = 0; m_ret = 0; m_stl = 0;
    for (int i = 0; i < NE; i++) m_evt[i] = 0;
    m_cov = 32'h0;
    m_fc  = 31'h0;
  endtask

  task automatic check_outputs(input int exp_rd);
    check("state",      64'(bus.state),      64'(m_state));
    check("done",       64'(bus.done),       64'(m_state >= ST_PASS));
    check("pass",       64'(bus.pass),       64'(m_state == ST_PASS));
    check("fail_code",  64'(bus.fail_code),  64'(m_fc));
    check("rf_cov",     64'(bus.rf_cov),     64'(m_cov));
    check("rf_cov_all", 64'(bus.rf_cov_all), 64'(m_cov == 32'hFFFF_FFFF));
    check("rd_data",    64'(bus.rd_data),    64'(exp_rd));
  endtask

  // Advance one clock: predict from the currently driven inputs, then compare.
  task automatic tick();
    int exp_rd;
    exp_rd = model_rd(int'(bus.rd_sel));
    if (m_state != ST_RUN) begin
      if (bus.start) begin
        m_state = ST_RUN;
        m_cyc = 0; m_ret = 0; m_stl = 0;
        for (int i = 0; i < NE; i++) m_evt[i] = 0;
        m_cov = 32'h1;
        m_fc  = 31'h0;
      end
    end else begin
      m_cyc = sat(m_cyc + 1);
      m_ret = sat(m_ret + int'(bus.inst_retire));
      m_stl = sat(m_stl + int'(bus.stall));
      for (int i = 0; i < NE; i++) m_evt[i] = sat(m_evt[i] + int'(bus.evt[i]));
      if (bus.rf_we) m_cov[bus.rf_addr] = 1'b1;
      if (bus.tohost_we && bus.tohost_data[0]) begin
        if (bus.tohost_data == 32'd1) m_state = ST_PASS;
        else begin
          m_state = ST_FAIL;
          m_fc    = bus.tohost_data[31:1];
        end
      end else if (bus.timeout_clocks != 0 && m_cyc == int'(bus.timeout_clocks)) begin
        m_state = ST_TO;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(exp_rd);
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.inst_retire = 1'b0;
    bus.stall       = 1'b0;
    bus.evt         = '0;
    bus.rf_we       = 1'b0;
    bus.rf_addr     = '0;
    bus.tohost_we   = 1'b0;
    bus.tohost_data = '0;
    bus.rd_sel      = '0;
  endtask

  task automatic rand_inputs();
    idle_inputs();
    bus.inst_retire = 1'($urandom);
    bus.stall       = 1'($urandom);
    bus.evt         = 2'($urandom);
    bus.rf_we       = 1'($urandom);
    bus.rf_addr     = 5'($urandom);
    bus.rd_sel      = 3'($urandom_range(0, 7));
  endtask

  task automatic start_run();
    rand_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic tohost(input logic [31:0] d);
    idle_inputs();
    bus.tohost_we   = 1'b1;
    bus.tohost_data = d;
    tick();
    bus.tohost_we   = 1'b0;
  endtask

  task automatic read_sel(input string tag, input int sel, input int exp);
    idle_inputs();
    bus.rd_sel = 3'(sel);
    tick();
    check(tag, 64'(bus.rd_data), 64'(exp));
  endtask

  initial begin
    logic [9:0] pat;
    int         addrs [30];

    idle_inputs();
    bus.timeout_clocks = '0;
    model_reset();
    #3;
    check_outputs(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Pass run: 10 RUN cycles, 5 retires, tohost=1 on the 10th
    pat = 10'b1011001010;
    start_run();
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      bus.inst_retire = pat[i];
      if (i == 9) begin
        bus.tohost_we   = 1'b1;
        bus.tohost_data = 32'h1;
      end
      tick();
    end
    bus.tohost_we = 1'b0;
    check("t1_state", 64'(bus.state), 64'(ST_PASS));
    check("t1_pass",  64'(bus.pass),  64'd1);
    read_sel("t1_cyc",     0, 10);
    read_sel("t1_instret", 1, 5);
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
    end
    read_sel("t1_cyc_hold",     0, 10);
    read_sel("t1_instret_hold", 1, 5);

    // Fail run with an ignored even write first
    start_run();
    for (int i = 0; i < 3; i++) begin rand_inputs(); tick(); end
    tohost(32'h6);
    check("t2_ignored", 64'(bus.state), 64'(ST_RUN));
    for (int i = 0; i < 2; i++) begin rand_inputs(); tick(); end
    tohost(32'h7);
    check("t2_state", 64'(bus.state),     64'(ST_FAIL));
    check("t2_code",  64'(bus.fail_code), 64'd3);
    check("t2_pass",  64'(bus.pass),      64'd0);

    // Watchdog
    bus.timeout_clocks = 8'd20;
    start_run();
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
      if (i == 18) check("t3_before", 64'(bus.state), 64'(ST_RUN));
    end
    check("t3_timeout", 64'(bus.state), 64'(ST_TO));
    read_sel("t3_cyc", 0, 20);
    start_run();
    for (int i = 0; i < 19; i++) begin rand_inputs(); tick(); end
    tohost(32'h1);
    check("t3_priority", 64'(bus.state), 64'(ST_PASS));
    bus.timeout_clocks = '0;
    start_run();
    for (int i = 0; i < 1000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 9) == 0) begin
        bus.tohost_we   = 1'b1;
        bus.tohost_data = $urandom & 32'hFFFF_FFFE;
      end
      tick();
    end
    check("t3_no_timeout", 64'(bus.state), 64'(ST_RUN));
    read_sel("t3_cyc_sat", 0, MAXC);

    // Saturation and event readout
    tohost(32'h1);
    start_run();
    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      bus.stall = 1'b1;
      bus.evt   = (i < 7) ? 2'b10 : 2'b00;
      tick();
    end
    tohost(32'h1);
    read_sel("t4_stall", 2, MAXC);
    read_sel("t4_evt1",  4, 7);
    read_sel("t4_evt0",  3, 0);
    read_sel("t4_sel6",  6, 0);
    read_sel("t4_sel7",  7, 0);

    // RF coverage, start ignored in RUN
    start_run();
    for (int i = 0; i < 30; i++) addrs[i] = i + 1;
    for (int i = 29; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = addrs[i]; addrs[i] = addrs[j]; addrs[j] = t;
    end
    for (int i = 0; i < 30; i++) begin
      idle_inputs();
      bus.rf_we   = 1'b1;
      bus.rf_addr = 5'(addrs[i]);
      tick();
    end
    check("t5_cov30",     64'(bus.rf_cov),     64'h7FFF_FFFF);
    check("t5_cov30_all", 64'(bus.rf_cov_all), 64'd0);
    idle_inputs();
    bus.start = 1'b1;
    tick();
    read_sel("t6_start_in_run", 0, 31);
    idle_inputs();
    bus.rf_we   = 1'b1;
    bus.rf_addr = 5'd31;
    tick();
    check("t5_cov32",     64'(bus.rf_cov),     64'hFFFF_FFFF);
    check("t5_cov32_all", 64'(bus.rf_cov_all), 64'd1);
    tohost(32'h1);
    start_run();
    check("t5_restart_cov", 64'(bus.rf_cov), 64'h1);

    // Async reset between edges
    for (int i = 0; i < 5; i++) begin rand_inputs(); tick(); end
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle", 64'(bus.state), 64'(ST_IDLE));

    // Randomized runs with random tohost writes, starts and timeouts
    for (int r = 0; r < 8; r++) begin
      bus.timeout_clocks = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(15, 60));
      start_run();
      for (int i = 0; i < 80; i++) begin
        rand_inputs();
        if ($urandom_range(0, 29) == 0) begin
          bus.tohost_we   = 1'b1;
          bus.tohost_data = ($urandom_range(0, 1) == 0) ? 32'h1 : $urandom;
        end
        if ($urandom_range(0, 39) == 0) bus.start = 1'b1;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ama_riscv_test_monitor.md
Name: ama_riscv_test_monitor

Overview:
Synthesizable run monitor that sits beside ama_riscv_core and observes the writeback-stage retire, stall, RF write and tohost CSR signals. It moves the testbench's completion logic into hardware: tohost pass/fail detection, a watchdog timeout, retire/cycle/stall performance counters, NUM_EVT generic event counters, and an RF first-write coverage bitmap. It is usable in simulation and on FPGA, and results are read back through a registered select port.

Parameters:
NUM_EVT, 4, number of generic event counter channels (1..16)
CNT_W, 64, width of every counter and of timeout_clocks (8..64)
TOHOST_PASS, 32'd1, tohost value that signals pass
SEL_W, $clog2(NUM_EVT+3), readout select width (derived, not overridden)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a run; clears all counters and coverage
inst_retire  in  1  non-nop, non-cleared instruction in WB this cycle
stall  in  1  front-end stall this cycle
evt  in  NUM_EVT  per-channel event strobes, one count per high cycle
rf_we  in  1  RF write enable
rf_addr  in  5  RF write address
tohost_we  in  1  tohost CSR write
tohost_data  in  32  tohost CSR write data
timeout_clocks  in  CNT_W  watchdog limit in RUN cycles; 0 disables the watchdog
rd_sel  in  SEL_W  readout select: 0 cycle, 1 instret, 2 stall, 3+i evt[i]
rd_data  out  CNT_W  selected counter, registered
state  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4
done  out  1  state is PASS, FAIL or TIMEOUT
pass  out  1  state is PASS
fail_code  out  31  tohost_data[31:1] of a failing write
rf_cov  out  32  bit n set once xn has been written
rf_cov_all  out  1  &rf_cov

Behaviour:
- Reset (rst_n low, asynchronous, no clock edge needed): state IDLE; all counters, rd_data, fail_code and rf_cov are 0; done, pass and rf_cov_all are 0.
- IDLE: counters hold. When start is high, the next edge moves to RUN, clears all counters and fail_code, and sets rf_cov to 32'h1 (x0 is hardwired and counts as covered).
- RUN, on each edge:
  - cycle_cnt += 1.
  - instret += inst_retire, stall_cnt += stall, evt_cnt[i] += evt[i].
  - Every counter saturates at all-ones and never wraps.
  - If rf_we is high, set rf_cov[rf_addr]. Writes to x0 are harmless.
- Completion on a tohost_we edge in RUN:
  - tohost_data[0] low: the write is ignored and the run continues.
  - tohost_data[0] high and tohost_data == TOHOST_PASS: go to PASS.
  - tohost_data[0] high, any other value: go to FAIL and latch fail_code = tohost_data[31:1].
  - Counter updates on the completing cycle are still applied.
- Watchdog: when timeout_clocks != 0 and the post-increment cycle_cnt == timeout_clocks, go to TIMEOUT on that edge.
  - Priority: a completing tohost write on the same cycle wins (PASS/FAIL, not TIMEOUT).
- Terminal states (PASS/FAIL/TIMEOUT):
  - All counters, rf_cov and fail_code freeze; done=1.
  - start moves to RUN with full clear (rerun without reset).
- start while in RUN is ignored (no clear).
- Readout: rd_data is registered from rd_sel, so data appears 1 cycle after rd_sel.
  - Readout is valid in every state.
  - An rd_sel value greater than NUM_EVT+2 returns 0.
- state, done, pass, fail_code, rf_cov and rf_cov_all are driven directly from flops; there is no combinational path from inputs.

Test Plan:
1. Pass run: start high 1 cycle; 10 RUN cycles with inst_retire high on 5 of them; tohost_we with data 32'h1 on the 10th. Next edge: state=2, done=1, pass=1, cycle_cnt=10, instret=5; counters hold for 20 further cycles.
2. Fail run: tohost_we with data 32'h0000_0007 in RUN gives state=3, fail_code=3, pass=0. A prior tohost write of 32'h0000_0006 was ignored (state stays 1).
3. Watchdog: timeout_clocks=20, no tohost gives state=4 exactly after RUN cycle 20 with cycle_cnt=20. Rerun with tohost 32'h1 on cycle 20 gives state=2 (tohost priority). With timeout_clocks=0, 1000 cycles elapse with no timeout.
4. Saturation and readout: CNT_W=8, NUM_EVT=2; stall high for 300 cycles gives stall_cnt=255; evt=2'b10 for 7 cycles gives rd_sel=4 returning 7 one cycle later; rd_sel=6 returns 0.
5. RF coverage: writes x1..x30 leave rf_cov=32'h7FFF_FFFF and rf_cov_all=0. A write to x31 gives 32'hFFFF_FFFF and rf_cov_all=1. A restart via start returns rf_cov to 32'h1.
6. Async reset: drop rst_n mid-RUN between clock edges; all outputs go to 0 and state to IDLE before the next edge. start in a terminal state reruns with cleared counters; start in RUN does not clear.
